// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
package mux_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int unsigned DEFAULT_MAX_HOLD = 8;

    // Hold counter width; keeps one bit when holding is unlimited so the vector stays legal.
    function automatic int unsigned hold_cnt_width(input int unsigned max_hold);
        return (max_hold == 0) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/mux4to1.sv
// Shared 4:1 datapath mux whose select is driven by the arbiter.
module mux4to1 #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    input  logic [1:0]   sel,
    output logic [W-1:0] out
);

    always_comb begin
        out = '0;
        case (sel)
            2'd0: out = in0;
            2'd1: out = in1;
            2'd2: out = in2;
            2'd3: out = in3;
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of vec at or after start, wrapping at NREQ.
module rr_pick #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned SEL_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  vec,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // NREQ is a power of two, so the SEL_W-bit add wraps for free.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = start + SEL_W'(i);
            if (!found && vec[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with bounded hold; registers one-hot grant and binary mux select.
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned SEL_W    = $clog2(NREQ),
    parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [SEL_W-1:0] sel,
    output logic             gnt_valid
);

    localparam int unsigned     HW       = hold_cnt_width(MAX_HOLD);
    localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0]   HOLD_ONE = HW'(1);
    localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(NREQ - 1);

    arb_state_t       state;
    logic [HW-1:0]    hold_cnt;
    logic [SEL_W-1:0] last_ptr;

    logic [NREQ-1:0]  cand_vec;
    logic [SEL_W-1:0] pick_start;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             owner_req;
    logic             preempt;

    // While granted, the owner is masked so pick_found means "someone else is waiting";
    // a released owner is already low, so the mask changes nothing in that case.
    always_comb begin
        cand_vec   = (state == GRANT) ? (req & ~gnt) : req;
        pick_start = last_ptr + SEL_W'(1);
        owner_req  = |(req & gnt);
        preempt    = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX) && pick_found;
    end

    rr_pick #(
        .NREQ  (NREQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .vec   (cand_vec),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            sel       <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
            last_ptr  <= PTR_RST;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        state     <= GRANT;
                        gnt       <= NREQ'(1) << pick_idx;
                        sel       <= pick_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= HOLD_ONE;
                        last_ptr  <= pick_idx;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        if (pick_found) begin
                            gnt      <= NREQ'(1) << pick_idx;
                            sel      <= pick_idx;
                            hold_cnt <= HOLD_ONE;
                            last_ptr <= pick_idx;
                        end else begin
                            state     <= IDLE;
                            gnt       <= '0;
                            gnt_valid <= 1'b0;
                            hold_cnt  <= '0;
                        end
                    end else if (preempt) begin
                        gnt      <= NREQ'(1) << pick_idx;
                        sel      <= pick_idx;
                        hold_cnt <= HOLD_ONE;
                        last_ptr <= pick_idx;
                    end else if ((MAX_HOLD != 0) && (hold_cnt != HOLD_MAX)) begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed and random-stream bench for mux4_rr_arbiter driving a shared mux4to1.
module tb_mux4_rr_arbiter;

    localparam int unsigned NREQ     = 4;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned MAX_HOLD = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  gnt;
    logic [SEL_W-1:0] sel;
    logic             gnt_valid;
    logic [7:0]       d0, d1, d2, d3;
    logic [7:0]       mux_out;

    int vectors     = 0;
    int miscompares = 0;
    bit mon_en      = 1'b0;
    bit rnd_en      = 1'b0;
    int max_wait    = 0;
    int wait_cnt [NREQ];
    logic [NREQ-1:0] req_s;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(
        .NREQ     (NREQ),
        .SEL_W    (SEL_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .gnt_valid (gnt_valid)
    );

    mux4to1 #(
        .W (8)
    ) u_mux (
        .in0 (d0),
        .in1 (d1),
        .in2 (d2),
        .in3 (d3),
        .sel (sel),
        .out (mux_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [7:0] dsel(input logic [SEL_W-1:0] s);
        case (s)
            2'd0: return d0;
            2'd1: return d1;
            2'd2: return d2;
            default: return d3;
        endcase
    endfunction

    always @(posedge clk) req_s <= req;

    // Invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            check("onehot0", 32'($onehot0(gnt)), 32'd1);
            check("valid_eq_or", 32'(gnt_valid), 32'(|gnt));
            check("gnt_le_req", 32'(gnt & ~req_s), 32'd0);
            if (gnt_valid) begin
                check("gnt_sel", 32'(gnt), 32'(4'b0001 << sel));
                check("mux_out", 32'(mux_out), 32'(dsel(sel)));
            end
        end
        if (rnd_en) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_s[i] && !gnt[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
        end
    end

    initial begin
        logic [3:0] exp_gnt;
        rst = 1'b1;
        req = 4'b1111;
        d0 = 8'hA0; d1 = 8'hB1; d2 = 8'hC2; d3 = 8'hD3;
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;

        // 1: reset with all requesting, then req0 wins first
        tick();
        mon_en = 1'b1;
        tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_valid", 32'(gnt_valid), 32'd0);
        rst = 1'b0;
        tick();
        check("first_gnt", 32'(gnt), 32'b0001);
        check("first_sel", 32'(sel), 32'd0);

        // 2: single requester from idle, then release keeps sel
        req = 4'b0000;
        do_reset();
        req = 4'b0100;
        tick();
        check("r2_gnt", 32'(gnt), 32'b0100);
        check("r2_sel", 32'(sel), 32'd2);
        check("r2_valid", 32'(gnt_valid), 32'd1);
        req = 4'b0000;
        tick();
        check("rel_gnt", 32'(gnt), 32'd0);
        check("rel_valid", 32'(gnt_valid), 32'd0);
        check("rel_sel", 32'(sel), 32'd2);

        // 3: all requesting, forced rotation every MAX_HOLD cycles
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 40; k++) begin
            tick();
            exp_gnt = 4'b0001 << ((k / MAX_HOLD) % NREQ);
            check("rot_gnt", 32'(gnt), 32'(exp_gnt));
        end

        // 4: owner drops as another asserts -> handover with no bubble
        req = 4'b0000;
        do_reset();
        req = 4'b0001;
        tick();
        check("ho_gnt0", 32'(gnt), 32'b0001);
        req = 4'b1000;
        tick();
        check("ho_gnt", 32'(gnt), 32'b1000);
        check("ho_valid", 32'(gnt_valid), 32'd1);
        check("ho_sel", 32'(sel), 32'd3);

        // 5: lone requester holds indefinitely; saturated counter preempts at once
        req = 4'b0000;
        do_reset();
        req = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("lone_gnt", 32'(gnt), 32'b0001);
        end
        req = 4'b0011;
        tick();
        check("sat_preempt", 32'(gnt), 32'b0010);

        // 6: reset mid-grant, then restart from req0
        req = 4'b0000;
        do_reset();
        req = 4'b0100;
        for (int k = 0; k < 5; k++) tick();
        check("mid_gnt", 32'(gnt), 32'b0100);
        rst = 1'b1;
        tick();
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        check("mid_rst_valid", 32'(gnt_valid), 32'd0);
        check("mid_rst_sel", 32'(sel), 32'd0);
        rst = 1'b0;
        req = 4'b1111;
        tick();
        check("post_rst_gnt", 32'(gnt), 32'b0001);

        // Random sticky request stream with varying data
        req = 4'b0000;
        do_reset();
        rnd_en = 1'b1;
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(15) == 0) req[i] = ~req[i];
            end
            d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom); d3 = 8'($urandom);
            tick();
        end
        rnd_en = 1'b0;
        check("starvation", 32'(max_wait <= 3 * MAX_HOLD), 32'd1);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
